// File: rtl/aes_ctr_mc_axis_engine.sv
// Multi-channel AES-CTR AXI-Stream engine: packet round-robin over NCH inputs, shared external
// keystream pipeline, per-channel counter contexts, single ciphertext master tagged with TDEST.
`timescale 1ns/1ps
module aes_ctr_mc_axis_engine #(
  parameter int NCH         = 4,
  parameter int CH_W        = 2,
  parameter int CTR_W       = 32,
  parameter int OUTSTANDING = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  soft_clr,
  input  logic                  ctx_load_valid,
  output logic                  ctx_load_ready,
  input  logic [CH_W-1:0]       ctx_load_ch,
  input  logic [127:0]          ctx_load_iv,
  input  logic [NCH*128-1:0]    s_axis_tdata,
  input  logic [NCH*16-1:0]     s_axis_tkeep,
  input  logic [NCH-1:0]        s_axis_tlast,
  input  logic [NCH-1:0]        s_axis_tvalid,
  output logic [NCH-1:0]        s_axis_tready,
  output logic                  ks_req_valid,
  input  logic                  ks_req_ready,
  output logic [127:0]          ks_req_block,
  input  logic                  ks_rsp_valid,
  input  logic [127:0]          ks_rsp_data,
  output logic [127:0]          m_axis_tdata,
  output logic [15:0]           m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [CH_W-1:0]       m_axis_tdest,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [63:0]           blocks_processed,
  output logic                  busy,
  output logic [NCH-1:0]        sts_ctr_wrap
);

  localparam int AW = $clog2(OUTSTANDING);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

  function automatic logic [127:0] keep_mask(input logic [127:0] d, input logic [15:0] k);
    logic [127:0] r;
    r = d;
    for (int i = 0; i < 16; i++) if (!k[i]) r[i*8 +: 8] = 8'h00;
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [CH_W-1:0]   gnt_q, gnt_d, rr_q, rr_d;
  logic [127:0]      ctx_q [NCH];
  logic [127:0]      ctx_d [NCH];
  logic [NCH-1:0]    wrap_q, wrap_d;
  logic [CW-1:0]     infl_q, infl_d, pend_q, pend_d;
  logic [AW-1:0]     dwp_q, dwp_d, drp_q, drp_d, kwp_q, kwp_d, krp_q, krp_d;
  logic [CW-1:0]     dcnt_q, dcnt_d, kcnt_q, kcnt_d;
  logic [127:0]      o_data_q, o_data_d;
  logic [15:0]       o_keep_q, o_keep_d;
  logic              o_last_q, o_last_d, o_vld_q, o_vld_d;
  logic [CH_W-1:0]   o_dest_q, o_dest_d;
  logic [63:0]       bp_q, bp_d;

  logic [127:0]      d_data_mem [OUTSTANDING];
  logic [15:0]       d_keep_mem [OUTSTANDING];
  logic              d_last_mem [OUTSTANDING];
  logic [CH_W-1:0]   d_ch_mem   [OUTSTANDING];
  logic [127:0]      k_mem      [OUTSTANDING];

  logic [127:0] sel_data;
  logic [15:0]  sel_keep;
  logic         sel_last, sel_valid;
  logic         credit, stream_rdy, accept, load_en;
  logic         out_pop, rsp_push, ks_avail, load_out, ks_pop, k_push;
  logic [127:0] ks_word;

  assign sel_data  = s_axis_tdata[int'(gnt_q)*128 +: 128];
  assign sel_keep  = s_axis_tkeep[int'(gnt_q)*16 +: 16];
  assign sel_last  = s_axis_tlast[gnt_q];
  assign sel_valid = s_axis_tvalid[gnt_q];

  assign credit     = (infl_q < CW'(OUTSTANDING));
  assign stream_rdy = (state_q == STREAM) && credit && ks_req_ready && !soft_clr;
  assign accept     = stream_rdy && sel_valid;
  assign load_en    = ctx_load_valid && ctx_load_ready &&
                      ({1'b0, ctx_load_ch} < (CH_W+1)'(NCH));

  // Keystream may bypass its FIFO straight into the output register when the FIFO is empty.
  assign out_pop  = o_vld_q && m_axis_tready;
  assign rsp_push = ks_rsp_valid && (pend_q != '0);
  assign ks_avail = (kcnt_q != '0) || rsp_push;
  assign ks_word  = (kcnt_q != '0) ? k_mem[krp_q] : ks_rsp_data;
  assign load_out = (dcnt_q != '0) && ks_avail && (!o_vld_q || m_axis_tready);
  assign ks_pop   = load_out && (kcnt_q != '0);
  assign k_push   = rsp_push && !(load_out && (kcnt_q == '0));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    int              idx;
    logic            found;
    logic [CH_W-1:0] idx_c;
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    found   = 1'b0;
    idx     = 0;
    idx_c   = '0;
    case (state_q)
      IDLE: begin
        for (int i = 0; i < NCH; i++) begin
          idx = int'(rr_q) + i;
          if (idx >= NCH) idx = idx - NCH;
          idx_c = CH_W'(idx);
          if (!found && s_axis_tvalid[idx_c]) begin
            found = 1'b1;
            gnt_d = idx_c;
          end
        end
        if (found) state_d = STREAM;
      end
      default: begin
        if (accept && sel_last) begin
          state_d = IDLE;
          rr_d    = (gnt_q == CH_W'(NCH-1)) ? '0 : gnt_q + CH_W'(1);
        end
      end
    endcase
    if (soft_clr) begin
      state_d = IDLE;
      gnt_d   = '0;
      rr_d    = '0;
    end
  end

  always_comb begin
    s_axis_tready  = stream_rdy ? (NCH'(1) << gnt_q) : '0;
    ks_req_valid   = accept;
    ks_req_block   = ctx_q[gnt_q];
    ctx_load_ready = !((state_q == STREAM) && (ctx_load_ch == gnt_q));
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) ctx_d[c] = ctx_q[c];
    wrap_d = wrap_q;
    if (accept) begin
      ctx_d[gnt_q][CTR_W-1:0] = ctx_q[gnt_q][CTR_W-1:0] + CTR_W'(1);
      if (&ctx_q[gnt_q][CTR_W-1:0]) wrap_d[gnt_q] = 1'b1;
    end
    if (load_en) begin
      ctx_d[ctx_load_ch]  = ctx_load_iv;
      wrap_d[ctx_load_ch] = 1'b0;
    end
    if (soft_clr) wrap_d = '0;
  end

  always_comb begin
    infl_d = infl_q;
    pend_d = pend_q;
    dcnt_d = dcnt_q;
    kcnt_d = kcnt_q;
    dwp_d  = dwp_q + AW'(accept);
    drp_d  = drp_q + AW'(load_out);
    kwp_d  = kwp_q + AW'(k_push);
    krp_d  = krp_q + AW'(ks_pop);
    case ({accept, out_pop})
      2'b10:   infl_d = infl_q + CW'(1);
      2'b01:   infl_d = infl_q - CW'(1);
      default: ;
    endcase
    case ({accept, rsp_push})
      2'b10:   pend_d = pend_q + CW'(1);
      2'b01:   pend_d = pend_q - CW'(1);
      default: ;
    endcase
    case ({accept, load_out})
      2'b10:   dcnt_d = dcnt_q + CW'(1);
      2'b01:   dcnt_d = dcnt_q - CW'(1);
      default: ;
    endcase
    case ({k_push, ks_pop})
      2'b10:   kcnt_d = kcnt_q + CW'(1);
      2'b01:   kcnt_d = kcnt_q - CW'(1);
      default: ;
    endcase
    o_vld_d  = o_vld_q;
    o_data_d = o_data_q;
    o_keep_d = o_keep_q;
    o_last_d = o_last_q;
    o_dest_d = o_dest_q;
    if (load_out) begin
      o_vld_d  = 1'b1;
      o_data_d = keep_mask(d_data_mem[drp_q] ^ ks_word, d_keep_mem[drp_q]);
      o_keep_d = d_keep_mem[drp_q];
      o_last_d = d_last_mem[drp_q];
      o_dest_d = d_ch_mem[drp_q];
    end else if (out_pop) begin
      o_vld_d = 1'b0;
    end
    bp_d = bp_q + 64'(out_pop);
    if (soft_clr) begin
      infl_d = '0; pend_d = '0; dcnt_d = '0; kcnt_d = '0;
      dwp_d  = '0; drp_d  = '0; kwp_d  = '0; krp_d  = '0;
      o_vld_d = 1'b0; o_data_d = '0; o_keep_d = '0; o_last_d = 1'b0; o_dest_d = '0;
      bp_d = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int c = 0; c < NCH; c++) ctx_q[c] <= '0;
      wrap_q <= '0;
      infl_q <= '0; pend_q <= '0; dcnt_q <= '0; kcnt_q <= '0;
      dwp_q  <= '0; drp_q  <= '0; kwp_q  <= '0; krp_q  <= '0;
      o_vld_q <= 1'b0; o_data_q <= '0; o_keep_q <= '0; o_last_q <= 1'b0; o_dest_q <= '0;
      bp_q   <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) ctx_q[c] <= ctx_d[c];
      wrap_q <= wrap_d;
      infl_q <= infl_d; pend_q <= pend_d; dcnt_q <= dcnt_d; kcnt_q <= kcnt_d;
      dwp_q  <= dwp_d;  drp_q  <= drp_d;  kwp_q  <= kwp_d;  krp_q  <= krp_d;
      o_vld_q <= o_vld_d; o_data_q <= o_data_d; o_keep_q <= o_keep_d;
      o_last_q <= o_last_d; o_dest_q <= o_dest_d;
      bp_q   <= bp_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (accept) begin
      d_data_mem[dwp_q] <= sel_data;
      d_keep_mem[dwp_q] <= sel_keep;
      d_last_mem[dwp_q] <= sel_last;
      d_ch_mem[dwp_q]   <= gnt_q;
    end
    if (k_push) k_mem[kwp_q] <= ks_rsp_data;
  end

  assign m_axis_tdata     = o_data_q;
  assign m_axis_tkeep     = o_keep_q;
  assign m_axis_tlast     = o_last_q;
  assign m_axis_tdest     = o_dest_q;
  assign m_axis_tvalid    = o_vld_q;
  assign blocks_processed = bp_q;
  assign busy             = (state_q != IDLE) || (infl_q != '0);
  assign sts_ctr_wrap     = wrap_q;

endmodule

// File: tb/tb_aes_ctr_mc_axis_engine.sv
// Directed bench for aes_ctr_mc_axis_engine with a fixed 4-stage keystream pipeline model.
`timescale 1ns/1ps
module tb_aes_ctr_mc_axis_engine;
  localparam int NCH = 4;
  localparam int CH_W = 2;
  localparam int CTR_W = 32;
  localparam int OUTSTANDING = 8;

  typedef struct packed { logic [127:0] data; logic [15:0] keep; logic last; } beat_t;
  typedef struct packed { logic [127:0] data; logic [15:0] keep; logic last; logic [1:0] dest; } obeat_t;

  logic aclk = 1'b0, aresetn, soft_clr;
  logic ctx_load_valid, ctx_load_ready;
  logic [CH_W-1:0] ctx_load_ch;
  logic [127:0] ctx_load_iv;
  logic [NCH*128-1:0] s_axis_tdata;
  logic [NCH*16-1:0] s_axis_tkeep;
  logic [NCH-1:0] s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic ks_req_valid, ks_req_ready, ks_rsp_valid;
  logic [127:0] ks_req_block, ks_rsp_data;
  logic [127:0] m_axis_tdata;
  logic [15:0] m_axis_tkeep;
  logic m_axis_tlast, m_axis_tvalid, m_axis_tready, busy;
  logic [CH_W-1:0] m_axis_tdest;
  logic [63:0] blocks_processed;
  logic [NCH-1:0] sts_ctr_wrap;

  beat_t drv_q [NCH][$];
  obeat_t out_q[$];
  logic [127:0] req_q[$];
  int checks = 0, passed = 0;

  always #5 aclk = ~aclk;

  aes_ctr_mc_axis_engine #(.NCH(NCH), .CH_W(CH_W), .CTR_W(CTR_W), .OUTSTANDING(OUTSTANDING)) dut (
    .aclk(aclk), .aresetn(aresetn), .soft_clr(soft_clr),
    .ctx_load_valid(ctx_load_valid), .ctx_load_ready(ctx_load_ready),
    .ctx_load_ch(ctx_load_ch), .ctx_load_iv(ctx_load_iv),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .ks_req_valid(ks_req_valid), .ks_req_ready(ks_req_ready), .ks_req_block(ks_req_block),
    .ks_rsp_valid(ks_rsp_valid), .ks_rsp_data(ks_rsp_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdest(m_axis_tdest), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .blocks_processed(blocks_processed), .busy(busy), .sts_ctr_wrap(sts_ctr_wrap)
  );

  function automatic logic [127:0] ks_fn(input logic [127:0] x);
    return x ^ {x[95:0], x[127:96]} ^ 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  endfunction

  function automatic logic [127:0] kmask(input logic [127:0] d, input logic [15:0] k);
    logic [127:0] r;
    r = d;
    for (int i = 0; i < 16; i++) if (!k[i]) r[i*8 +: 8] = 8'h00;
    return r;
  endfunction

  function automatic logic [127:0] pt_of(input int ch, input int k);
    return {32'(ch) * 32'h0101_0101 ^ 32'hC0FF_EE00, 32'hA5A5_0000 + 32'(k),
            32'h1234_5678, 32'(k) * 32'h1111_1111 + 32'(ch)};
  endfunction

  function automatic obeat_t exp_of(input logic [127:0] pt, input logic [15:0] keep,
                                    input logic last, input int dest, input logic [127:0] ctr);
    obeat_t r;
    r.data = kmask(pt ^ ks_fn(ctr), keep);
    r.keep = keep;
    r.last = last;
    r.dest = 2'(dest);
    return r;
  endfunction

  // External keystream pipeline: fixed latency of 4 stages, reset with the engine.
  logic [3:0]   ks_v;
  logic [127:0] ks_d [4];
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ks_v <= '0;
      for (int i = 0; i < 4; i++) ks_d[i] <= '0;
    end else begin
      ks_v[0] <= ks_req_valid && ks_req_ready;
      ks_d[0] <= ks_fn(ks_req_block);
      for (int i = 1; i < 4; i++) begin
        ks_v[i] <= ks_v[i-1];
        ks_d[i] <= ks_d[i-1];
      end
    end
  end
  assign ks_rsp_valid = ks_v[3];
  assign ks_rsp_data  = ks_d[3];

  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready)
      out_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest});
    if (aresetn && ks_req_valid && ks_req_ready)
      req_q.push_back(ks_req_block);
  end

  task automatic drive(input int budget);
    logic [NCH-1:0] hs;
    bit any;
    for (int n = 0; n < budget; n++) begin
      any = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        if (drv_q[c].size() > 0) begin
          s_axis_tvalid[c] = 1'b1;
          s_axis_tdata[c*128 +: 128] = drv_q[c][0].data;
          s_axis_tkeep[c*16 +: 16] = drv_q[c][0].keep;
          s_axis_tlast[c] = drv_q[c][0].last;
          any = 1'b1;
        end else begin
          s_axis_tvalid[c] = 1'b0;
        end
      end
      if (!any) break;
      @(negedge aclk);
      hs = s_axis_tvalid & s_axis_tready;
      @(posedge aclk); #1;
      for (int c = 0; c < NCH; c++) if (hs[c]) void'(drv_q[c].pop_front());
    end
  endtask

  task automatic load_ctx(input int ch, input logic [127:0] iv);
    logic r;
    ctx_load_valid = 1'b1;
    ctx_load_ch = CH_W'(ch);
    ctx_load_iv = iv;
    for (int n = 0; n < 20; n++) begin
      @(negedge aclk); r = ctx_load_ready;
      @(posedge aclk); #1;
      if (r) break;
    end
    ctx_load_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget);
    int t;
    t = 0;
    while (out_q.size() < n && t < budget) begin
      @(posedge aclk); #1;
      t++;
    end
    if (out_q.size() < n) begin
      checks++;
      $display("FAIL wait_out: got %0d beats, required %0d", out_q.size(), n);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({ctx_load_ready, busy, m_axis_tvalid, s_axis_tready, ks_req_valid, sts_ctr_wrap} !== 12'b1000_0000_0000)
      $display("FAIL %s_ctrl: got %b required 100000000000", tag,
               {ctx_load_ready, busy, m_axis_tvalid, s_axis_tready, ks_req_valid, sts_ctr_wrap});
    else passed++;
    checks++;
    if (blocks_processed !== 64'd0) $display("FAIL %s_bp: got %0d required 0", tag, blocks_processed);
    else passed++;
    checks++;
    if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest} !== '0)
      $display("FAIL %s_mdata: got %h required 0", tag, m_axis_tdata);
    else passed++;
  endtask

  task automatic test_reset();
    #1 check_idle_outputs("reset_held");
    @(posedge aclk); #1 aresetn = 1'b1;
    @(posedge aclk); #1 check_idle_outputs("reset_rel");
  endtask

  task automatic test_single_packet();
    logic [127:0] iv;
    int rb, ob;
    iv = {96'h0123_4567_89AB_CDEF_0011_2233, 32'h0000_0001};
    load_ctx(0, iv);
    rb = req_q.size(); ob = out_q.size();
    for (int k = 0; k < 3; k++) drv_q[0].push_back({pt_of(0, k), 16'hFFFF, k == 2});
    drive(100);
    wait_out(ob + 3, 200);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (req_q[rb+k] !== {iv[127:32], 32'(1 + k)})
        $display("FAIL single_req%0d: got %h required %h", k, req_q[rb+k], {iv[127:32], 32'(1 + k)});
      else passed++;
      checks++;
      if (out_q[ob+k] !== exp_of(pt_of(0, k), 16'hFFFF, k == 2, 0, {iv[127:32], 32'(1 + k)}))
        $display("FAIL single_out%0d: got %h required %h", k, out_q[ob+k],
                 exp_of(pt_of(0, k), 16'hFFFF, k == 2, 0, {iv[127:32], 32'(1 + k)}));
      else passed++;
    end
    checks++;
    if (blocks_processed !== 64'd3) $display("FAIL single_bp: got %0d required 3", blocks_processed);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [127:0] iv1, iv3, ctr;
    int ob, ch, k;
    iv1 = {96'h1111_1111_2222_2222_3333_3333, 32'h0000_0100};
    iv3 = {96'h3333_3333_4444_4444_5555_5555, 32'h0000_0300};
    load_ctx(1, iv1);
    load_ctx(3, iv3);
    ob = out_q.size();
    for (int j = 0; j < 4; j++) begin
      drv_q[1].push_back({pt_of(1, j), 16'hFFFF, j % 2 == 1});
      drv_q[3].push_back({pt_of(3, j), 16'hFFFF, j % 2 == 1});
    end
    drive(200);
    wait_out(ob + 8, 300);
    for (int i = 0; i < 8; i++) begin
      ch = ((i / 2) % 2 == 1) ? 3 : 1;
      k = (i / 4) * 2 + (i % 2);
      ctr = (ch == 1) ? iv1 : iv3;
      ctr[31:0] = ctr[31:0] + 32'(k);
      checks++;
      if (out_q[ob+i] !== exp_of(pt_of(ch, k), 16'hFFFF, k % 2 == 1, ch, ctr))
        $display("FAIL rr_out%0d: got %h required %h", i, out_q[ob+i],
                 exp_of(pt_of(ch, k), 16'hFFFF, k % 2 == 1, ch, ctr));
      else passed++;
    end
    checks++;
    if (blocks_processed !== 64'd11) $display("FAIL rr_bp: got %0d required 11", blocks_processed);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [127:0] iv, ctr;
    int rb, ob;
    iv = {96'h2222_2222_6666_6666_7777_7777, 32'h0000_0010};
    load_ctx(2, iv);
    m_axis_tready = 1'b0;
    rb = req_q.size(); ob = out_q.size();
    for (int k = 0; k < 12; k++) drv_q[2].push_back({pt_of(2, k), 16'hFFFF, k == 5 || k == 11});
    drive(40);
    @(negedge aclk);
    checks++;
    if (req_q.size() - rb !== OUTSTANDING)
      $display("FAIL bp_reqs: got %0d required %0d", req_q.size() - rb, OUTSTANDING);
    else passed++;
    checks++;
    if (s_axis_tready !== 4'b0000) $display("FAIL bp_tready: got %b required 0000", s_axis_tready);
    else passed++;
    checks++;
    if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, exp_of(pt_of(2, 0), 16'hFFFF, 1'b0, 2, iv).data})
      $display("FAIL bp_hold: got %b/%h required 1/%h", m_axis_tvalid, m_axis_tdata,
               exp_of(pt_of(2, 0), 16'hFFFF, 1'b0, 2, iv).data);
    else passed++;
    @(posedge aclk); #1 m_axis_tready = 1'b1;
    drive(200);
    wait_out(ob + 12, 300);
    for (int k = 0; k < 12; k++) begin
      ctr = iv;
      ctr[31:0] = ctr[31:0] + 32'(k);
      checks++;
      if (out_q[ob+k] !== exp_of(pt_of(2, k), 16'hFFFF, k == 5 || k == 11, 2, ctr))
        $display("FAIL bp_out%0d: got %h required %h", k, out_q[ob+k],
                 exp_of(pt_of(2, k), 16'hFFFF, k == 5 || k == 11, 2, ctr));
      else passed++;
    end
    checks++;
    if (blocks_processed !== 64'd23) $display("FAIL bp_count: got %0d required 23", blocks_processed);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [127:0] iv, c1;
    int rb, ob;
    iv = {96'h5555_5555_AAAA_AAAA_5A5A_5A5A, 32'hFFFF_FFFF};
    c1 = {96'h5555_5555_AAAA_AAAA_5A5A_5A5A, 32'h0000_0000};
    load_ctx(1, iv);
    rb = req_q.size(); ob = out_q.size();
    for (int k = 0; k < 2; k++) drv_q[1].push_back({pt_of(1, 10 + k), 16'hFFFF, k == 1});
    drive(100);
    wait_out(ob + 2, 200);
    checks++;
    if ({req_q[rb], req_q[rb+1]} !== {iv, c1})
      $display("FAIL wrap_req: got %h %h required %h %h", req_q[rb], req_q[rb+1], iv, c1);
    else passed++;
    checks++;
    if (out_q[ob+1] !== exp_of(pt_of(1, 11), 16'hFFFF, 1'b1, 1, c1))
      $display("FAIL wrap_out: got %h required %h", out_q[ob+1], exp_of(pt_of(1, 11), 16'hFFFF, 1'b1, 1, c1));
    else passed++;
    checks++;
    if (sts_ctr_wrap !== 4'b0010) $display("FAIL wrap_sticky: got %b required 0010", sts_ctr_wrap);
    else passed++;
    load_ctx(1, iv);
    checks++;
    if (sts_ctr_wrap !== 4'b0000) $display("FAIL wrap_clear: got %b required 0000", sts_ctr_wrap);
    else passed++;
  endtask

  task automatic test_tkeep();
    logic [127:0] ctr;
    int ob;
    ctr = {96'h0123_4567_89AB_CDEF_0011_2233, 32'h0000_0005};
    ob = out_q.size();
    drv_q[0].push_back({pt_of(0, 20), 16'hFFFF, 1'b0});
    drv_q[0].push_back({pt_of(0, 21), 16'h00FF, 1'b1});
    drive(100);
    wait_out(ob + 2, 200);
    checks++;
    if (out_q[ob+1].data[127:64] !== 64'd0)
      $display("FAIL keep_upper: got %h required 0", out_q[ob+1].data[127:64]);
    else passed++;
    checks++;
    if (out_q[ob+1] !== exp_of(pt_of(0, 21), 16'h00FF, 1'b1, 0, ctr))
      $display("FAIL keep_beat: got %h required %h", out_q[ob+1], exp_of(pt_of(0, 21), 16'h00FF, 1'b1, 0, ctr));
    else passed++;
  endtask

  task automatic test_mid_reset();
    int rb, ob;
    m_axis_tready = 1'b0;
    rb = req_q.size();
    for (int k = 0; k < 5; k++) drv_q[2].push_back({pt_of(2, 30 + k), 16'hFFFF, 1'b0});
    drive(100);
    @(negedge aclk);
    checks++;
    if ({busy, 32'(req_q.size() - rb)} !== {1'b1, 32'd5})
      $display("FAIL mid_inflight: got busy=%b reqs=%0d required busy=1 reqs=5", busy, req_q.size() - rb);
    else passed++;
    #1 aresetn = 1'b0;
    #1 check_idle_outputs("mid_reset");
    @(posedge aclk); @(posedge aclk); #1 aresetn = 1'b1;
    m_axis_tready = 1'b1;
    ob = out_q.size();
    drv_q[0].push_back({pt_of(0, 40), 16'hFFFF, 1'b1});
    drive(100);
    wait_out(ob + 1, 200);
    repeat (20) @(posedge aclk);
    #1;
    checks++;
    if (out_q[ob] !== exp_of(pt_of(0, 40), 16'hFFFF, 1'b1, 0, 128'd0))
      $display("FAIL mid_after: got %h required %h", out_q[ob], exp_of(pt_of(0, 40), 16'hFFFF, 1'b1, 0, 128'd0));
    else passed++;
    checks++;
    if ({32'(out_q.size() - ob), blocks_processed, busy} !== {32'd1, 64'd1, 1'b0})
      $display("FAIL mid_count: got beats=%0d bp=%0d busy=%b required 1/1/0",
               out_q.size() - ob, blocks_processed, busy);
    else passed++;
  endtask

  initial begin
    aresetn = 1'b0; soft_clr = 1'b0;
    ctx_load_valid = 1'b0; ctx_load_ch = '0; ctx_load_iv = '0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = '0; s_axis_tvalid = '0;
    ks_req_ready = 1'b1; m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_tkeep();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
